lut_seq_counter: RTL and testbench

//  Parametrised LUT-driven sequence counter. Next state is count <= table[count], with a runtime-programmable

---
 rtl/counter_pkg.sv | 17 +
 rtl/lut_next_state_ram.sv | 32 +++
 rtl/lut_seq_counter.sv | 107 ++++++++++
 tb/tb_lut_seq_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the LUT-driven sequence counter: FSM state encoding
// and the power-on next-state function used to fill the table.
// Latency: n/a (package). Backpressure: n/a.
package counter_pkg;

  // INIT rewrites the table after every reset; RUN steps the counter.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Default table entry: a binary up-counter that wraps at 2**width.
  function automatic int default_next(input int i, input int width);
    return (i + 1) % (1 << width);
  endfunction

endpackage

// File: rtl/lut_next_state_ram.sv
// Next-state table: DEPTH x WIDTH register array, one sync write port, one async read port.
// Latency: read is combinational; a write becomes visible the cycle after the write edge.
// Backpressure: none; writes are accepted every cycle, contents are not reset.
//
// Ports:
//   clk              rising-edge clock
//   we/waddr/wdata   synchronous write port
//   raddr/rdata      asynchronous read port
module lut_next_state_ram #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_seq_counter.sv
// LUT-driven sequence counter: count <= table[count], with a runtime-programmable table.
// Latency: one step per enabled edge; ready rises DEPTH+1 edges after reset release.
// Backpressure: none; en/load/wr_en are ignored while ready=0 (table being initialised).
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   en, load, load_val       step / synchronous load (load wins over en)
//   wr_en, wr_addr, wr_data  table programming, honoured only once ready
//   ready, count, wrap       status, current state, 1-cycle return-to-zero pulse
module lut_seq_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             ready,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam int DEPTH = 1 << WIDTH;

  state_e           state;
  logic [WIDTH-1:0] init_ptr;
  // Set once the last entry has been written; the FSM leaves INIT on the
  // following edge so every entry is in place before the first step.
  logic             init_done;

  logic             ram_we;
  logic [WIDTH-1:0] ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] init_val;

  assign init_val = WIDTH'(default_next(int'(init_ptr), WIDTH));

  // INIT owns the write port; afterwards it belongs to the user.
  always_comb begin
    ram_we    = wr_en;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state == ST_INIT) begin
      ram_we    = ~init_done;
      ram_waddr = init_ptr;
      ram_wdata = init_val;
    end
  end

  // Async read on count: a same-cycle write to entry count is seen only
  // after the edge, so a simultaneous step uses the old entry.
  lut_next_state_ram #(
    .WIDTH (WIDTH)
  ) u_table (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (count),
    .rdata (next_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      init_done <= 1'b0;
      ready     <= 1'b0;
      count     <= '0;
      wrap      <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          wrap <= 1'b0;
          if (init_done) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            if (init_ptr == WIDTH'(DEPTH - 1)) begin
              init_done <= 1'b1;
            end
            init_ptr <= init_ptr + WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (load) begin
            count <= load_val;
            wrap  <= 1'b0;
          end else if (en) begin
            count <= next_val;
            wrap  <= (next_val == '0);
          end else begin
            wrap  <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_seq_counter.sv
// Directed bench for lut_seq_counter: a WIDTH=2 instance for the main tests
// and a WIDTH=4 instance for the long-sequence test.
module tb_lut_seq_counter;

  logic clk;

  // WIDTH=2 instance
  logic       reset_n, en, load, wr_en;
  logic [1:0] load_val, wr_addr, wr_data;
  logic       ready, wrap;
  logic [1:0] count;

  // WIDTH=4 instance
  logic       reset4_n, en4;
  logic       ready4, wrap4;
  logic [3:0] count4;

  int n_chk  = 0;
  int n_fail = 0;

  lut_seq_counter #(.WIDTH(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ready    (ready),
    .count    (count),
    .wrap     (wrap)
  );

  lut_seq_counter #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .reset_n  (reset4_n),
    .en       (en4),
    .load     (1'b0),
    .load_val (4'd0),
    .wr_en    (1'b0),
    .wr_addr  (4'd0),
    .wr_data  (4'd0),
    .ready    (ready4),
    .count    (count4),
    .wrap     (wrap4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input logic [1:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // INIT phase with en held: ready low for 4 edges, high on the 5th, count 0 throughout.
  task automatic check_init2(input string tag);
    for (int i = 1; i <= 4; i++) begin
      step();
      check({tag, " init ready"}, ready, 0);
      check({tag, " init count"}, count, 0);
    end
    step();
    check({tag, " ready rises"}, ready, 1);
    check({tag, " count after init"}, count, 0);
  endtask

  int exp_seq_def [4]  = '{1, 2, 3, 0};
  int exp_seq_gray [5] = '{1, 3, 2, 0, 1};

  initial begin
    reset_n = 1'b0; en = 1'b1; load = 1'b0; load_val = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    reset4_n = 1'b0; en4 = 1'b0;
    #2;
    check("reset count", count, 0);
    check("reset ready", ready, 0);
    check("reset wrap", wrap, 0);
    step();

    // Test 1: init then default up-count
    reset_n = 1'b1;
    check_init2("t1");
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1 count", count, exp_seq_def[i]);
      check("t1 wrap", wrap, (exp_seq_def[i] == 0) ? 1 : 0);
    end

    // Test 2: Gray table
    en = 1'b0;
    tbl_write(2'd0, 2'd1);
    tbl_write(2'd1, 2'd3);
    tbl_write(2'd3, 2'd2);
    tbl_write(2'd2, 2'd0);
    check("t2 hold during writes", count, 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2 gray count", count, exp_seq_gray[i]);
      check("t2 gray wrap", wrap, (exp_seq_gray[i] == 0) ? 1 : 0);
    end

    // Test 3: load has priority over en, then hold
    step();  // 1 -> 3
    step();  // 3 -> 2
    check("t3 pre count", count, 2);
    load = 1'b1; load_val = 2'd1;
    step();
    check("t3 load count", count, 1);
    check("t3 load wrap", wrap, 0);
    load = 1'b0; en = 1'b0;
    step();
    check("t3 hold count", count, 1);
    check("t3 hold wrap", wrap, 0);

    // Test 4: write-during-step uses old entry. Restore entry 1 -> 2 first.
    tbl_write(2'd1, 2'd2);
    en = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 2'd0;
    step();
    wr_en = 1'b0; en = 1'b0;
    check("t4 old entry used", count, 2);
    load = 1'b1; load_val = 2'd1;
    step();
    load = 1'b0;
    check("t4 reload", count, 1);
    en = 1'b1;
    step();
    en = 1'b0;
    check("t4 new entry count", count, 0);
    check("t4 new entry wrap", wrap, 1);

    // Test 5: mid-run reset, INIT ignores load/wr_en and restores default table
    load = 1'b1; load_val = 2'd3;
    step();
    load = 1'b0;
    check("t5 pre count", count, 3);
    reset_n = 1'b0;
    #1;
    check("t5 reset count", count, 0);
    check("t5 reset ready", ready, 0);
    check("t5 reset wrap", wrap, 0);
    reset_n = 1'b1;
    en = 1'b1; load = 1'b1; load_val = 2'd3;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 2'd0;
    check_init2("t5");
    load = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5 default count", count, exp_seq_def[i]);
      check("t5 default wrap", wrap, (exp_seq_def[i] == 0) ? 1 : 0);
    end
    en = 1'b0;

    // Test 6: WIDTH=4 instance
    check("t6 reset ready", ready4, 0);
    reset4_n = 1'b1; en4 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("t6 init ready", ready4, 0);
      check("t6 init count", count4, 0);
    end
    step();
    check("t6 ready rises", ready4, 1);
    check("t6 count after init", count4, 0);
    for (int i = 1; i <= 17; i++) begin
      step();
      check("t6 count", count4, i % 16);
      check("t6 wrap", wrap4, (i == 16) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
